// File: rtl/led_rgb_pkg.sv
// Shared types and constants for the RGB LED arbiter.
// Colours are logical R,G,B with R in the MSB.
package led_rgb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [2:0] BLACK = 3'b000;
    localparam logic [2:0] RED   = 3'b100;
    localparam logic [2:0] GREEN = 3'b010;
    localparam logic [2:0] BLUE  = 3'b001;
    localparam logic [2:0] WHITE = 3'b111;

endpackage

// File: rtl/led_rr_pick.sv
// Combinational round-robin picker.
// The search starts at ptr+1 and wraps modulo NREQ.
module led_rr_pick #(
    parameter int NREQ  = 3,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx,
    output logic [NREQ-1:0]  onehot
);

    always_comb begin
        int               c;
        logic [IDX_W-1:0] cidx;
        c      = 0;
        cidx   = '0;
        valid  = 1'b0;
        idx    = '0;
        onehot = '0;
        // Walk from the farthest candidate to the nearest one, so the first
        // requester after ptr is the last to overwrite the result.
        for (int i = NREQ; i >= 1; i--) begin
            c    = (int'(ptr) + i) % NREQ;
            cidx = IDX_W'(c);
            if (req[cidx]) begin
                valid = 1'b1;
                idx   = cidx;
            end
        end
        if (valid) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/led_rgb_arb.sv
// Round-robin sharing of one RGB LED between NREQ requesters.
// Each grant shows a latched colour for max(hold,1) cycles, followed by a blank gap.
module led_rgb_arb
    import led_rgb_pkg::*;
#(
    parameter int         NREQ           = 3,
    parameter int         HOLD_W         = 24,
    parameter int         GAP_CYCLES     = 4,
    parameter logic [2:0] IDLE_COLOR     = 3'b000,
    parameter bit         LED_ACTIVE_LOW = 1'b1
) (
    input  logic                   sysclk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [3*NREQ-1:0]      color,
    input  logic [HOLD_W*NREQ-1:0] hold,
    output logic [NREQ-1:0]        gnt,
    output logic [NREQ-1:0]        done,
    output logic                   busy,
    output logic [2:0]             leds
);

    localparam int               IDX_W    = $clog2(NREQ);
    localparam int               GAP_W    = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);

    function automatic logic [2:0] apply_polarity(input logic [2:0] c);
        return LED_ACTIVE_LOW ? ~c : c;
    endfunction

    function automatic logic [HOLD_W-1:0] hold_floor(input logic [HOLD_W-1:0] h);
        return (h == '0) ? HOLD_W'(1) : h;
    endfunction

    state_t            state, state_nx;
    logic [IDX_W-1:0]  ptr;
    logic [NREQ-1:0]   win_oh;
    logic [HOLD_W-1:0] hold_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic [2:0]        color_q;

    logic              pick_vld;
    logic [IDX_W-1:0]  pick_idx;
    logic [NREQ-1:0]   pick_oh;
    logic [2:0]        color_sel;
    logic [HOLD_W-1:0] hold_sel;
    logic              win_req, show_last, show_exit;

    logic [NREQ-1:0]   gnt_nx, done_nx;
    logic              busy_nx;
    logic [2:0]        color_nx;

    led_rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req    (req),
        .ptr    (ptr),
        .valid  (pick_vld),
        .idx    (pick_idx),
        .onehot (pick_oh)
    );

    always_comb begin
        color_sel = '0;
        hold_sel  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                color_sel = color[3*i +: 3];
                hold_sel  = hold[HOLD_W*i +: HOLD_W];
            end
        end
    end

    // A dropped request ends SHOW exactly like the final hold cycle, minus the done pulse.
    assign win_req   = |(req & win_oh);
    assign show_last = (hold_cnt <= HOLD_W'(1));
    assign show_exit = show_last || !win_req;

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (pick_vld) state_nx = SHOW;
            SHOW:    if (show_exit) state_nx = (GAP_CYCLES == 0) ? IDLE : GAP;
            GAP:     if (gap_cnt <= GAP_W'(1)) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        gnt_nx   = '0;
        done_nx  = '0;
        busy_nx  = (state_nx != IDLE);
        color_nx = IDLE_COLOR;
        if (state_nx == SHOW) begin
            gnt_nx   = (state == IDLE) ? pick_oh : win_oh;
            color_nx = (state == IDLE) ? color_sel : color_q;
        end
        if (state == SHOW && show_exit && win_req) begin
            done_nx = win_oh;
        end
    end

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            ptr      <= IDX_W'(NREQ - 1);
            win_oh   <= '0;
            hold_cnt <= '0;
            gap_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        ptr      <= pick_idx;
                        win_oh   <= pick_oh;
                        hold_cnt <= hold_floor(hold_sel);
                    end
                end
                SHOW: begin
                    if (show_exit) begin
                        gap_cnt <= GAP_LOAD;
                    end else if (hold_cnt != '0) begin
                        hold_cnt <= hold_cnt - HOLD_W'(1);
                    end
                end
                GAP: begin
                    if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge sysclk) begin
        if (state == IDLE && pick_vld) begin
            color_q <= color_sel;
        end
    end

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            gnt  <= '0;
            done <= '0;
            busy <= 1'b0;
            leds <= apply_polarity(IDLE_COLOR);
        end else begin
            gnt  <= gnt_nx;
            done <= done_nx;
            busy <= busy_nx;
            leds <= apply_polarity(color_nx);
        end
    end

endmodule

// File: tb/tb_led_rgb_arb.sv
// Directed bench for led_rgb_arb: a default instance plus a GAP_CYCLES=0 instance.
// Inputs are driven and outputs sampled on the falling edge of sysclk.
module tb_led_rgb_arb;
    import led_rgb_pkg::*;

    localparam int NREQ   = 3;
    localparam int HOLD_W = 24;

    logic                   sysclk = 1'b0;
    logic                   rst;
    logic [NREQ-1:0]        req, b_req;
    logic [3*NREQ-1:0]      color, b_color;
    logic [HOLD_W*NREQ-1:0] hold, b_hold;
    logic [NREQ-1:0]        gnt, done, b_gnt, b_done;
    logic                   busy, b_busy;
    logic [2:0]             leds, b_leds;

    int checks = 0;
    int errors = 0;

    led_rgb_arb #(
        .NREQ(NREQ), .HOLD_W(HOLD_W), .GAP_CYCLES(4),
        .IDLE_COLOR(3'b000), .LED_ACTIVE_LOW(1'b1)
    ) dut (
        .sysclk(sysclk), .rst(rst), .req(req), .color(color), .hold(hold),
        .gnt(gnt), .done(done), .busy(busy), .leds(leds)
    );

    led_rgb_arb #(
        .NREQ(NREQ), .HOLD_W(HOLD_W), .GAP_CYCLES(0),
        .IDLE_COLOR(3'b000), .LED_ACTIVE_LOW(1'b1)
    ) dut_b2b (
        .sysclk(sysclk), .rst(rst), .req(b_req), .color(b_color), .hold(b_hold),
        .gnt(b_gnt), .done(b_done), .busy(b_busy), .leds(b_leds)
    );

    always #5 sysclk = ~sysclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic [9:0] obs();
        return {gnt, done, busy, leds};
    endfunction

    function automatic logic [9:0] obs_b();
        return {b_gnt, b_done, b_busy, b_leds};
    endfunction

    task automatic step();
        @(negedge sysclk);
    endtask

    task automatic do_reset();
        req   = '0;
        b_req = '0;
        rst   = 1'b1;
        step();
        rst   = 1'b0;
        step();
    endtask

    task automatic test_reset();
        logic [9:0] exp;
        do_reset();
        exp = {3'b000, 3'b000, 1'b0, 3'b111};
        checks++;
        if (obs() !== exp) begin
            errors++;
            $display("FAIL reset_idle got=%b want=%b", obs(), exp);
        end
        checks++;
        if (obs_b() !== exp) begin
            errors++;
            $display("FAIL reset_idle_b2b got=%b want=%b", obs_b(), exp);
        end
        color[2:0]  = RED;
        hold[23:0]  = 24'd5;
        req         = 3'b001;
        step();
        step();
        exp = {3'b001, 3'b000, 1'b1, 3'b011};
        checks++;
        if (obs() !== exp) begin
            errors++;
            $display("FAIL reset_pre_show got=%b want=%b", obs(), exp);
        end
        #2 rst = 1'b1;
        #1;
        exp = {3'b000, 3'b000, 1'b0, 3'b111};
        checks++;
        if (obs() !== exp) begin
            errors++;
            $display("FAIL reset_async got=%b want=%b", obs(), exp);
        end
        req = '0;
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (obs() !== exp) begin
                errors++;
                $display("FAIL reset_release cyc=%0d got=%b want=%b", i, obs(), exp);
            end
        end
    endtask

    task automatic test_single();
        logic [9:0] exp;
        do_reset();
        color[2:0] = RED;
        hold[23:0] = 24'd5;
        req        = 3'b001;
        for (int i = 1; i <= 5; i++) begin
            step();
            exp = {3'b001, 3'b000, 1'b1, 3'b011};
            checks++;
            if (obs() !== exp) begin
                errors++;
                $display("FAIL single_show cyc=%0d got=%b want=%b", i, obs(), exp);
            end
        end
        step();
        req = '0;
        exp = {3'b000, 3'b001, 1'b1, 3'b111};
        checks++;
        if (obs() !== exp) begin
            errors++;
            $display("FAIL single_done got=%b want=%b", obs(), exp);
        end
        for (int i = 2; i <= 4; i++) begin
            step();
            exp = {3'b000, 3'b000, 1'b1, 3'b111};
            checks++;
            if (obs() !== exp) begin
                errors++;
                $display("FAIL single_gap gapcyc=%0d got=%b want=%b", i, obs(), exp);
            end
        end
        step();
        exp = {3'b000, 3'b000, 1'b0, 3'b111};
        checks++;
        if (obs() !== exp) begin
            errors++;
            $display("FAIL single_idle got=%b want=%b", obs(), exp);
        end
    endtask

    task automatic test_round_robin();
        logic [9:0] exp;
        logic [2:0] rr_col [3];
        logic [2:0] oh;
        logic [2:0] col;
        rr_col[0] = RED;
        rr_col[1] = GREEN;
        rr_col[2] = BLUE;
        do_reset();
        b_color = {BLUE, GREEN, RED};
        b_hold  = {24'd2, 24'd2, 24'd2};
        b_req   = 3'b111;
        for (int k = 0; k < 5; k++) begin
            oh  = 3'b001 << (k % 3);
            col = ~rr_col[k % 3];
            for (int j = 0; j < 2; j++) begin
                step();
                exp = {oh, 3'b000, 1'b1, col};
                checks++;
                if (obs_b() !== exp) begin
                    errors++;
                    $display("FAIL rr_show grant=%0d cyc=%0d got=%b want=%b", k, j, obs_b(), exp);
                end
            end
            step();
            exp = {3'b000, oh, 1'b0, 3'b111};
            checks++;
            if (obs_b() !== exp) begin
                errors++;
                $display("FAIL rr_idle grant=%0d got=%b want=%b", k, obs_b(), exp);
            end
        end
        b_req = '0;
    endtask

    task automatic test_hold_zero();
        logic [9:0] exp;
        do_reset();
        color[8:6]  = GREEN;
        hold[71:48] = 24'd0;
        req         = 3'b100;
        step();
        exp = {3'b100, 3'b000, 1'b1, 3'b101};
        checks++;
        if (obs() !== exp) begin
            errors++;
            $display("FAIL hold0_show got=%b want=%b", obs(), exp);
        end
        step();
        req = '0;
        exp = {3'b000, 3'b100, 1'b1, 3'b111};
        checks++;
        if (obs() !== exp) begin
            errors++;
            $display("FAIL hold0_done got=%b want=%b", obs(), exp);
        end
        for (int i = 0; i < 4; i++) step();
        exp = {3'b000, 3'b000, 1'b0, 3'b111};
        checks++;
        if (obs() !== exp) begin
            errors++;
            $display("FAIL hold0_idle got=%b want=%b", obs(), exp);
        end
    endtask

    task automatic test_abort();
        logic [9:0] exp;
        do_reset();
        color[5:3]  = BLUE;
        hold[47:24] = 24'd10;
        color[8:6]  = WHITE;
        hold[71:48] = 24'd1;
        req         = 3'b110;
        for (int i = 1; i <= 3; i++) begin
            step();
            exp = {3'b010, 3'b000, 1'b1, 3'b110};
            checks++;
            if (obs() !== exp) begin
                errors++;
                $display("FAIL abort_show cyc=%0d got=%b want=%b", i, obs(), exp);
            end
        end
        req = 3'b100;
        for (int i = 1; i <= 4; i++) begin
            step();
            exp = {3'b000, 3'b000, 1'b1, 3'b111};
            checks++;
            if (obs() !== exp) begin
                errors++;
                $display("FAIL abort_gap gapcyc=%0d got=%b want=%b", i, obs(), exp);
            end
        end
        step();
        exp = {3'b000, 3'b000, 1'b0, 3'b111};
        checks++;
        if (obs() !== exp) begin
            errors++;
            $display("FAIL abort_arb_cycle got=%b want=%b", obs(), exp);
        end
        step();
        exp = {3'b100, 3'b000, 1'b1, 3'b000};
        checks++;
        if (obs() !== exp) begin
            errors++;
            $display("FAIL abort_next_grant got=%b want=%b", obs(), exp);
        end
        step();
        req = '0;
        exp = {3'b000, 3'b100, 1'b1, 3'b111};
        checks++;
        if (obs() !== exp) begin
            errors++;
            $display("FAIL abort_next_done got=%b want=%b", obs(), exp);
        end
    endtask

    task automatic test_latch();
        logic [9:0] exp;
        do_reset();
        color[2:0] = RED;
        hold[23:0] = 24'd8;
        req        = 3'b001;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (i == 1) begin
                color[2:0] = BLUE;
                hold[23:0] = 24'd1;
            end
            exp = {3'b001, 3'b000, 1'b1, 3'b011};
            checks++;
            if (obs() !== exp) begin
                errors++;
                $display("FAIL latch_show cyc=%0d got=%b want=%b", i, obs(), exp);
            end
        end
        step();
        req = '0;
        exp = {3'b000, 3'b001, 1'b1, 3'b111};
        checks++;
        if (obs() !== exp) begin
            errors++;
            $display("FAIL latch_done got=%b want=%b", obs(), exp);
        end
    endtask

    initial begin
        rst     = 1'b1;
        req     = '0;
        b_req   = '0;
        color   = '0;
        hold    = '0;
        b_color = '0;
        b_hold  = '0;
        step();
        test_reset();
        test_single();
        test_round_robin();
        test_hold_zero();
        test_abort();
        test_latch();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
